// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the wait-stated MEM-stage data memory.
package dmem_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned WORD_W    = 8 * NUM_LANES;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Drops the offset bits a half or word access cannot use; size 2'b11 behaves as a word.
  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] size,
                                                     input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicates right-aligned store data so every enabled lane sees its bytes.
  function automatic logic [WORD_W-1:0] place_wdata(input logic [1:0] size,
                                                    input logic [WORD_W-1:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] extract(input logic [1:0] size, input logic [1:0] off,
                                                input logic [WORD_W-1:0] word);
    logic [WORD_W-1:0] shifted;
    shifted = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: return {24'h0, shifted[7:0]};
      SZ_HALF: return {16'h0, shifted[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_waitstate_if.sv
// Request/response bus of the data memory. rsp_err exists only when DMEM_ERR_EN is defined.
interface data_mem_waitstate_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
`ifdef DMEM_ERR_EN
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy, rsp_err
  );
`else
  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
`endif

endinterface

// File: rtl/dmem_lane_array.sv
// Four byte-wide storage arrays sharing one word index, with per-lane write and registered read.
module dmem_lane_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic [NUM_LANES-1:0] we_i,
  input  logic [WORD_W-1:0]    wdata_i,
  input  logic                 re_i,
  output logic [WORD_W-1:0]    rdata_o
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem_q [DEPTH_WORDS];
    logic [7:0] rd_q;

    // Memory is never reset; contents survive a pipeline reset.
    always_ff @(posedge clk) begin
      if (we_i[l]) begin
        mem_q[idx_i] <= wdata_i[8*l +: 8];
      end
      if (re_i) begin
        rd_q <= mem_q[idx_i];
      end
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/data_mem_waitstate.sv
// MEM-stage data memory with byte/half/word lanes and WAIT_CYCLES wait states.
// Optional DMEM_ERR_EN: flag misaligned / out-of-range accesses on rsp_err instead of storing.
module data_mem_waitstate
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_waitstate_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              in_idle;
  logic              accept;
  logic              commit;
  logic              op_we;
  logic [1:0]        op_size;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [1:0]        op_off;
  logic              op_err;
  logic [NUM_LANES-1:0] arr_we;
  logic              arr_re;
  logic [WORD_W-1:0] arr_rdata;
  logic [DATA_W-1:0] resp_val;

  assign in_idle = (state_q == ST_IDLE);
  assign accept  = in_idle && bus.req_valid;

  // With zero wait states the commit edge is the accept edge, so the raw request drives the array.
  assign op_we    = in_idle ? bus.req_we    : we_q;
  assign op_size  = in_idle ? bus.req_size  : size_q;
  assign op_addr  = in_idle ? bus.req_addr  : addr_q;
  assign op_wdata = in_idle ? bus.req_wdata : wdata_q;
  assign op_off   = align_off(op_size, op_addr[1:0]);

`ifdef DMEM_ERR_EN
  logic op_misalign;
  logic op_oob;
  assign op_misalign = ((op_size == SZ_HALF) && op_addr[0]) ||
                       (op_size[1] && (op_addr[1:0] != 2'b00));
  assign op_oob      = (op_addr >> (IDX_W + 2)) != '0;
  assign op_err      = op_misalign || op_oob;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^op_addr[ADDR_W-1:IDX_W+2];
  assign op_err         = 1'b0;
`endif

  assign commit = (accept && (WAIT_CYCLES == 0)) ||
                  ((state_q == ST_WAIT) && (cnt_q == CNT_LAST));
  assign arr_we = (commit && op_we && !op_err) ? lane_mask(op_size, op_off) : '0;
  assign arr_re = commit && !op_we && !op_err;

  dmem_lane_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_lane_array (
    .clk     (clk),
    .idx_i   (op_addr[IDX_W+1:2]),
    .we_i    (arr_we),
    .wdata_i (place_wdata(op_size, op_wdata)),
    .re_i    (arr_re),
    .rdata_o (arr_rdata)
  );

  assign resp_val = (err_q || we_q) ? '0
                                    : extract(size_q, align_off(size_q, addr_q[1:0]), arr_rdata);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = op_err;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        hold_d  = resp_val;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.req_ready = in_idle;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.busy      = (state_q == ST_WAIT) || (state_q == ST_RESP);
  // Load data is live during the response pulse and held afterwards.
  assign bus.rsp_rdata = (state_q == ST_RESP) ? resp_val : hold_q;
`ifdef DMEM_ERR_EN
  assign bus.rsp_err   = (state_q == ST_RESP) && err_q;
`endif

endmodule

// File: tb/tb_data_mem_waitstate.sv
// Directed bench for data_mem_waitstate with default parameters (WAIT_CYCLES=2, 1024 words).
module tb_data_mem_waitstate;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  data_mem_waitstate_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  data_mem_waitstate #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the response pulse.
  task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int lat,
                        output logic err);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.rsp_rdata;
`ifdef DMEM_ERR_EN
    err = bus.rsp_err;
`else
    err = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata: got %h expected 00000000", bus.rsp_rdata);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_round_trip();
    logic [31:0] rd;
    int          lat;
    logic        err;
    do_req(1'b1, 2'b10, 32'h400, 32'h12345678, rd, lat, err);
    checks++;
    if (lat != 3) begin
      failures++; $display("FAIL rt_store_latency: got %0d expected 3", lat);
    end
    checks++;
    if (rd !== 32'h0) begin
      failures++; $display("FAIL rt_store_rdata: got %h expected 00000000", rd);
    end
    do_req(1'b0, 2'b10, 32'h400, 32'h0, rd, lat, err);
    checks++;
    if (lat != 3) begin
      failures++; $display("FAIL rt_load_latency: got %0d expected 3", lat);
    end
    checks++;
    if (rd !== 32'h12345678) begin
      failures++; $display("FAIL rt_load_data: got %h expected 12345678", rd);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    int          lat;
    logic        err;
    int          seen;
    do_req(1'b1, 2'b10, 32'h10, 32'h11111111, rd, lat, err);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_abort_state: got busy=%b ready=%b expected busy=0 ready=1",
               bus.busy, bus.req_ready);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      if (bus.rsp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL rst_abort_no_rsp: got %0d pulses expected 0", seen);
    end
    do_req(1'b0, 2'b10, 32'h10, 32'h0, rd, lat, err);
    checks++;
    if (rd !== 32'h11111111) begin
      failures++; $display("FAIL rst_abort_data: got %h expected 11111111", rd);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd;
    int          lat;
    logic        err;
    do_req(1'b1, 2'b10, 32'h20, 32'h00000000, rd, lat, err);
    do_req(1'b1, 2'b00, 32'h22, 32'hFFFFFFAB, rd, lat, err);
    do_req(1'b1, 2'b01, 32'h20, 32'hFFFFCDEF, rd, lat, err);
    do_req(1'b0, 2'b10, 32'h20, 32'h0, rd, lat, err);
    checks++;
    if (rd !== 32'h00ABCDEF) begin
      failures++; $display("FAIL lanes_word: got %h expected 00abcdef", rd);
    end
    do_req(1'b0, 2'b01, 32'h22, 32'h0, rd, lat, err);
    checks++;
    if (rd !== 32'h000000AB) begin
      failures++; $display("FAIL lanes_half_hi: got %h expected 000000ab", rd);
    end
    do_req(1'b0, 2'b01, 32'h20, 32'h0, rd, lat, err);
    checks++;
    if (rd !== 32'h0000CDEF) begin
      failures++; $display("FAIL lanes_half_lo: got %h expected 0000cdef", rd);
    end
    do_req(1'b0, 2'b00, 32'h22, 32'h0, rd, lat, err);
    checks++;
    if (rd !== 32'h000000AB) begin
      failures++; $display("FAIL lanes_byte: got %h expected 000000ab", rd);
    end
    checks++;
    if (bus.rsp_rdata !== 32'h000000AB || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL lanes_hold: got rdata=%h valid=%b expected rdata=000000ab valid=0",
               bus.rsp_rdata, bus.rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'hCAFEF00D;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_first_ready: got %b expected 1", bus.req_ready);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_we    = 1'b0;
        bus.req_wdata = 32'h0;
      end
      checks++;
      if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1 || bus.rsp_valid !== (c == 3)) begin
        failures++;
        $display("FAIL b2b_pending_c%0d: got ready=%b busy=%b valid=%b expected 0 1 %0d",
                 c, bus.req_ready, bus.busy, bus.rsp_valid, (c == 3));
      end
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept: got ready=%b busy=%b valid=%b expected 1 0 0",
               bus.req_ready, bus.busy, bus.rsp_valid);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 3 || bus.rsp_rdata !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL b2b_second_rsp: got lat=%0d data=%h expected lat=3 data=cafef00d",
               n, bus.rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    int          lat;
    logic        err;
    do_req(1'b1, 2'b10, 32'h4, 32'h0, rd, lat, err);
    do_req(1'b1, 2'b10, 32'h1004, 32'h55AA55AA, rd, lat, err);
`ifdef DMEM_ERR_EN
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL wrap_err: got %b expected 1", err);
    end
`else
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL wrap_err: got %b expected 0", err);
    end
`endif
    do_req(1'b0, 2'b10, 32'h4, 32'h0, rd, lat, err);
`ifdef DMEM_ERR_EN
    checks++;
    if (rd !== 32'h0) begin
      failures++; $display("FAIL wrap_data: got %h expected 00000000", rd);
    end
`else
    checks++;
    if (rd !== 32'h55AA55AA) begin
      failures++; $display("FAIL wrap_data: got %h expected 55aa55aa", rd);
    end
`endif
  endtask

  task automatic test_misalign();
    logic [31:0] rd;
    int          lat;
    logic        err;
    do_req(1'b0, 2'b10, 32'h401, 32'h0, rd, lat, err);
`ifdef DMEM_ERR_EN
    checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL misalign_word: got err=%b data=%h expected 1 00000000", err, rd);
    end
`else
    checks++;
    if (err !== 1'b0 || rd !== 32'h12345678) begin
      failures++; $display("FAIL misalign_word: got err=%b data=%h expected 0 12345678", err, rd);
    end
`endif
    do_req(1'b0, 2'b11, 32'h400, 32'h0, rd, lat, err);
    checks++;
    if (rd !== 32'h12345678) begin
      failures++; $display("FAIL size11_word: got %h expected 12345678", rd);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    test_reset();
    test_word_round_trip();
    test_reset_mid_wait();
    test_lanes();
    test_back_to_back();
    test_wrap();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
